// File: rtl/cr16_pkg.sv
// cr16_pkg: shared constants and types for the CR16 issue controller.
//   - data / register-index widths
//   - opcode and opext encodings used by the decoder
//   - CLFZN flag bit positions
//   - controller state, operand-class and A-operand-source enums
//   - imm8 extension helper
package cr16_pkg;

    localparam int unsigned DW = 16;
    localparam int unsigned RW = 4;

    // Primary opcodes (instr[15:12])
    localparam logic [3:0] OP_RTYPE = 4'b0000;
    localparam logic [3:0] OP_ADDI  = 4'b0101;
    localparam logic [3:0] OP_ADDUI = 4'b0110;
    localparam logic [3:0] OP_ADDCI = 4'b0111;
    localparam logic [3:0] OP_SHIFT = 4'b1000;
    localparam logic [3:0] OP_SUBI  = 4'b1001;
    localparam logic [3:0] OP_EXT   = 4'b1010;
    localparam logic [3:0] OP_CMPI  = 4'b1011;
    localparam logic [3:0] OP_MOVI  = 4'b1101;
    localparam logic [3:0] OP_MULI  = 4'b1110;

    // Register-form opexts under OP_RTYPE
    localparam logic [3:0] EXT_AND  = 4'b0001;
    localparam logic [3:0] EXT_OR   = 4'b0010;
    localparam logic [3:0] EXT_XOR  = 4'b0011;
    localparam logic [3:0] EXT_ADD  = 4'b0101;
    localparam logic [3:0] EXT_ADDU = 4'b0110;
    localparam logic [3:0] EXT_ADDC = 4'b0111;
    localparam logic [3:0] EXT_SUB  = 4'b1001;
    localparam logic [3:0] EXT_CMP  = 4'b1011;
    localparam logic [3:0] EXT_MOV  = 4'b1101;
    localparam logic [3:0] EXT_MUL  = 4'b1110;

    // Register-form opexts under OP_EXT (valid range 0001..0110) and OP_SHIFT
    localparam logic [3:0] EXT_ADDCU   = 4'b0001;
    localparam logic [3:0] EXT_CMPU    = 4'b0010;
    localparam logic [3:0] EXT_EXT_MIN = 4'b0001;
    localparam logic [3:0] EXT_EXT_MAX = 4'b0110;
    localparam logic [3:0] EXT_LSH     = 4'b0100;

    // CLFZN bit positions
    localparam int unsigned FLAG_C = 4;
    localparam int unsigned FLAG_L = 3;
    localparam int unsigned FLAG_F = 2;
    localparam int unsigned FLAG_Z = 1;
    localparam int unsigned FLAG_N = 0;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_READ,
        ST_EXEC,
        ST_WB
    } state_e;

    typedef enum logic [1:0] {
        CLS_NOP,
        CLS_REG,
        CLS_IMM,
        CLS_ILLEGAL
    } opclass_e;

    typedef enum logic [1:0] {
        ASEL_RDEST,
        ASEL_RSRC,
        ASEL_IMM
    } asel_e;

    function automatic logic [DW-1:0] ext_imm8(input logic [7:0] imm, input logic zext);
        return zext ? {8'h00, imm} : {{8{imm[7]}}, imm};
    endfunction

endpackage

// File: rtl/cr16_decode.sv
// cr16_decode: combinational instruction decoder.
//   instr_i   : latched 16-bit instruction word
//   cls_o     : operand class (NOP / register / immediate / illegal)
//   wb_o      : instruction writes Rdest
//   flags_o   : instruction updates the PSR CLFZN flags
//   zext_o    : imm8 is zero-extended (otherwise sign-extended)
//   asel_o    : source of ALU operand A
//   illegal_o : word is not a recognised encoding
module cr16_decode
    import cr16_pkg::*;
(
    input  logic [DW-1:0] instr_i,
    output opclass_e      cls_o,
    output logic          wb_o,
    output logic          flags_o,
    output logic          zext_o,
    output asel_e         asel_o,
    output logic          illegal_o
);

    logic [3:0] opcode;
    logic [3:0] opext;

    assign opcode = instr_i[15:12];
    assign opext  = instr_i[7:4];

    always_comb begin
        cls_o   = CLS_ILLEGAL;
        wb_o    = 1'b0;
        flags_o = 1'b0;
        zext_o  = 1'b0;
        asel_o  = ASEL_RDEST;
        case (opcode)
            OP_RTYPE: begin
                // Only the all-zero word is NOP; other opext-0000 words are illegal.
                if (instr_i == '0) begin
                    cls_o = CLS_NOP;
                end else begin
                    case (opext)
                        EXT_AND, EXT_OR, EXT_XOR, EXT_MUL: begin
                            cls_o = CLS_REG;
                            wb_o  = 1'b1;
                        end
                        EXT_ADD, EXT_ADDU, EXT_ADDC, EXT_SUB: begin
                            cls_o   = CLS_REG;
                            wb_o    = 1'b1;
                            flags_o = 1'b1;
                        end
                        EXT_CMP: begin
                            cls_o   = CLS_REG;
                            flags_o = 1'b1;
                        end
                        EXT_MOV: begin
                            cls_o  = CLS_REG;
                            wb_o   = 1'b1;
                            asel_o = ASEL_RSRC;
                        end
                        default: ;
                    endcase
                end
            end
            OP_EXT: begin
                if (opext >= EXT_EXT_MIN && opext <= EXT_EXT_MAX) begin
                    cls_o   = CLS_REG;
                    wb_o    = (opext != EXT_CMPU);
                    flags_o = (opext == EXT_ADDCU) || (opext == EXT_CMPU);
                end
            end
            OP_SHIFT: begin
                cls_o = (opext == EXT_LSH) ? CLS_REG : CLS_IMM;
                wb_o  = 1'b1;
            end
            OP_ADDI, OP_ADDCI, OP_SUBI: begin
                cls_o   = CLS_IMM;
                wb_o    = 1'b1;
                flags_o = 1'b1;
            end
            OP_ADDUI: begin
                cls_o   = CLS_IMM;
                wb_o    = 1'b1;
                flags_o = 1'b1;
                zext_o  = 1'b1;
            end
            OP_CMPI: begin
                cls_o   = CLS_IMM;
                flags_o = 1'b1;
            end
            OP_MOVI: begin
                cls_o  = CLS_IMM;
                wb_o   = 1'b1;
                asel_o = ASEL_IMM;
            end
            OP_MULI: begin
                cls_o = CLS_IMM;
                wb_o  = 1'b1;
            end
            default: ;
        endcase
        illegal_o = (cls_o == CLS_ILLEGAL);
    end

endmodule

// File: rtl/cr16_exec_ctrl.sv
// cr16_exec_ctrl: four-state instruction-issue controller for the CR16 ALU.
//   clk, rst_n             : clock, async active-low reset
//   instr_valid/ready/instr: fetch handshake (ready only in IDLE)
//   ra_addr/rb_addr        : register-file read addresses (Rdest, Rsrc)
//   ra_data/rb_data        : combinational register-file read data
//   alu_a/b/opcode/opext   : registered ALU inputs, stable through EXEC
//   alu_s/alu_flags        : ALU result and CLFZN flags
//   wb_en/wb_addr/wb_data  : one-cycle register writeback
//   psr_flags              : architectural CLFZN register
//   done/illegal           : retirement pulse / undecodable-word pulse
module cr16_exec_ctrl
    import cr16_pkg::*;
(
    input  logic          clk,
    input  logic          rst_n,
    input  logic          instr_valid,
    output logic          instr_ready,
    input  logic [DW-1:0] instr,
    output logic [RW-1:0] ra_addr,
    output logic [RW-1:0] rb_addr,
    input  logic [DW-1:0] ra_data,
    input  logic [DW-1:0] rb_data,
    output logic [DW-1:0] alu_a,
    output logic [DW-1:0] alu_b,
    output logic [3:0]    alu_opcode,
    output logic [3:0]    alu_opext,
    input  logic [DW-1:0] alu_s,
    input  logic [4:0]    alu_flags,
    output logic          wb_en,
    output logic [RW-1:0] wb_addr,
    output logic [DW-1:0] wb_data,
    output logic [4:0]    psr_flags,
    output logic          done,
    output logic          illegal
);

    state_e        state_q, state_d;
    logic [DW-1:0] instr_q, instr_d;
    logic [DW-1:0] alu_a_q, alu_a_d, alu_b_q, alu_b_d;
    logic [3:0]    opcode_q, opcode_d, opext_q, opext_d;
    logic [RW-1:0] wb_addr_q, wb_addr_d;
    logic [DW-1:0] wb_data_q, wb_data_d;
    logic [4:0]    psr_q, psr_d;
    logic          wb_en_q, wb_en_d, done_q, done_d, illegal_q, illegal_d;

    opclass_e      dec_cls;
    asel_e         dec_asel;
    logic          dec_wb, dec_flags, dec_zext, dec_illegal;
    logic [DW-1:0] imm16;

    cr16_decode u_decode (
        .instr_i   (instr_q),
        .cls_o     (dec_cls),
        .wb_o      (dec_wb),
        .flags_o   (dec_flags),
        .zext_o    (dec_zext),
        .asel_o    (dec_asel),
        .illegal_o (dec_illegal)
    );

    assign imm16 = ext_imm8(instr_q[7:0], dec_zext);

    always_comb begin
        state_d   = state_q;
        instr_d   = instr_q;
        alu_a_d   = alu_a_q;
        alu_b_d   = alu_b_q;
        opcode_d  = opcode_q;
        opext_d   = opext_q;
        wb_addr_d = wb_addr_q;
        wb_data_d = wb_data_q;
        psr_d     = psr_q;
        wb_en_d   = 1'b0;
        done_d    = 1'b0;
        illegal_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (instr_valid) begin
                    instr_d = instr;
                    state_d = ST_READ;
                end
            end
            ST_READ: begin
                case (dec_asel)
                    ASEL_RSRC: alu_a_d = rb_data;
                    ASEL_IMM:  alu_a_d = imm16;
                    default:   alu_a_d = ra_data;
                endcase
                alu_b_d  = (dec_cls == CLS_IMM) ? imm16 : rb_data;
                opcode_d = instr_q[15:12];
                opext_d  = instr_q[7:4];
                state_d  = ST_EXEC;
            end
            ST_EXEC: begin
                // Results are registered at the end of EXEC so that wb_en, done
                // and the updated PSR all become visible together in WB.
                wb_addr_d = instr_q[11:8];
                wb_data_d = alu_s;
                wb_en_d   = dec_wb;
                done_d    = 1'b1;
                illegal_d = dec_illegal;
                if (dec_flags) begin
                    psr_d = alu_flags;
                end
                state_d = ST_WB;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            instr_q   <= '0;
            alu_a_q   <= '0;
            alu_b_q   <= '0;
            opcode_q  <= '0;
            opext_q   <= '0;
            wb_addr_q <= '0;
            wb_data_q <= '0;
            psr_q     <= '0;
            wb_en_q   <= 1'b0;
            done_q    <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            instr_q   <= instr_d;
            alu_a_q   <= alu_a_d;
            alu_b_q   <= alu_b_d;
            opcode_q  <= opcode_d;
            opext_q   <= opext_d;
            wb_addr_q <= wb_addr_d;
            wb_data_q <= wb_data_d;
            psr_q     <= psr_d;
            wb_en_q   <= wb_en_d;
            done_q    <= done_d;
            illegal_q <= illegal_d;
        end
    end

    assign instr_ready = rst_n && (state_q == ST_IDLE);
    assign ra_addr     = instr_q[11:8];
    assign rb_addr     = instr_q[3:0];
    assign alu_a       = alu_a_q;
    assign alu_b       = alu_b_q;
    assign alu_opcode  = opcode_q;
    assign alu_opext   = opext_q;
    assign wb_en       = wb_en_q;
    assign wb_addr     = wb_addr_q;
    assign wb_data     = wb_data_q;
    assign psr_flags   = psr_q;
    assign done        = done_q;
    assign illegal     = illegal_q;

endmodule

// File: tb/tb_cr16_exec_ctrl.sv
// tb_cr16_exec_ctrl: directed, table-driven bench for cr16_exec_ctrl.
// The bench plays register file (combinational read of regs[]) and ALU
// (returns the result/flags listed in each vector).
module tb_cr16_exec_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        instr_valid;
    logic        instr_ready;
    logic [15:0] instr;
    logic [3:0]  ra_addr, rb_addr;
    logic [15:0] ra_data, rb_data;
    logic [15:0] alu_a, alu_b;
    logic [3:0]  alu_opcode, alu_opext;
    logic [15:0] alu_s;
    logic [4:0]  alu_flags;
    logic        wb_en;
    logic [3:0]  wb_addr;
    logic [15:0] wb_data;
    logic [4:0]  psr_flags;
    logic        done;
    logic        illegal;

    logic [15:0] regs [16];

    always #5 clk = ~clk;

    assign ra_data = regs[ra_addr];
    assign rb_data = regs[rb_addr];

    cr16_exec_ctrl dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .instr       (instr),
        .ra_addr     (ra_addr),
        .rb_addr     (rb_addr),
        .ra_data     (ra_data),
        .rb_data     (rb_data),
        .alu_a       (alu_a),
        .alu_b       (alu_b),
        .alu_opcode  (alu_opcode),
        .alu_opext   (alu_opext),
        .alu_s       (alu_s),
        .alu_flags   (alu_flags),
        .wb_en       (wb_en),
        .wb_addr     (wb_addr),
        .wb_data     (wb_data),
        .psr_flags   (psr_flags),
        .done        (done),
        .illegal     (illegal)
    );

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [15:0] instr;
        logic [15:0] rd_val;   // R[Rdest]
        logic [15:0] rs_val;   // R[Rsrc]
        logic [15:0] s;        // ALU result returned by the bench
        logic [4:0]  flags;    // ALU flags returned by the bench
        logic        chk_ops;  // operands are defined for this class
        logic [15:0] a;
        logic [15:0] b;
        logic        wb;
        logic [4:0]  psr;      // PSR expected after retirement
        logic        ill;
    } vec_t;

    vec_t vecs [22];

    // Assumes the DUT is in IDLE, 1 time unit after a rising edge.
    task automatic run_vec(input vec_t v, input int idx);
        regs[v.instr[11:8]] = v.rd_val;
        regs[v.instr[3:0]]  = v.rs_val;
        instr       = v.instr;
        instr_valid = 1'b1;
        chk($sformatf("v%0d_ready_idle", idx), instr_ready, 1);
        @(posedge clk); #1;
        instr_valid = 1'b0;
        chk($sformatf("v%0d_ready_read", idx), instr_ready, 0);
        @(posedge clk); #1;
        alu_s     = v.s;
        alu_flags = v.flags;
        chk($sformatf("v%0d_ready_exec", idx), instr_ready, 0);
        chk($sformatf("v%0d_opcode", idx), alu_opcode, v.instr[15:12]);
        chk($sformatf("v%0d_opext", idx), alu_opext, v.instr[7:4]);
        if (v.chk_ops) begin
            chk($sformatf("v%0d_alu_a", idx), alu_a, v.a);
            chk($sformatf("v%0d_alu_b", idx), alu_b, v.b);
        end
        @(posedge clk); #1;
        chk($sformatf("v%0d_wb_en", idx), wb_en, v.wb);
        chk($sformatf("v%0d_done", idx), done, 1);
        chk($sformatf("v%0d_illegal", idx), illegal, v.ill);
        chk($sformatf("v%0d_psr", idx), psr_flags, v.psr);
        if (v.wb) begin
            chk($sformatf("v%0d_wb_addr", idx), wb_addr, v.instr[11:8]);
            chk($sformatf("v%0d_wb_data", idx), wb_data, v.s);
        end
        @(posedge clk); #1;
        chk($sformatf("v%0d_ready_next", idx), instr_ready, 1);
        chk($sformatf("v%0d_done_clr", idx), done, 0);
        chk($sformatf("v%0d_wb_en_clr", idx), wb_en, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "bench timeout");
    end

    initial begin
        //            instr     rd       rs       s        flags     ops a        b        wb psr       ill
        vecs[0]  = '{16'h0152, 16'h7FFF, 16'h0001, 16'h8000, 5'b00100, 1, 16'h7FFF, 16'h0001, 1, 5'b00100, 0}; // ADD
        vecs[1]  = '{16'h6301, 16'hFFFF, 16'h1234, 16'h0000, 5'b10010, 1, 16'hFFFF, 16'h0001, 1, 5'b10010, 0}; // ADDUI
        vecs[2]  = '{16'hD480, 16'h0000, 16'h0000, 16'hFF80, 5'b00001, 1, 16'hFF80, 16'hFF80, 1, 5'b10010, 0}; // MOVI
        vecs[3]  = '{16'h05B6, 16'h0003, 16'h0005, 16'hFFFE, 5'b01001, 1, 16'h0003, 16'h0005, 0, 5'b01001, 0}; // CMP
        vecs[4]  = '{16'h0F00, 16'hAAAA, 16'h5555, 16'hAAAA, 5'b11111, 0, 16'h0000, 16'h0000, 0, 5'b01001, 1}; // illegal
        vecs[5]  = '{16'h0000, 16'h0000, 16'h0000, 16'h1234, 5'b11111, 0, 16'h0000, 16'h0000, 0, 5'b01001, 0}; // NOP
        vecs[6]  = '{16'h07D8, 16'h1111, 16'h2222, 16'h2222, 5'b00000, 1, 16'h2222, 16'h2222, 1, 5'b01001, 0}; // MOV
        vecs[7]  = '{16'h0999, 16'h0042, 16'h0042, 16'h0000, 5'b00010, 1, 16'h0042, 16'h0042, 1, 5'b00010, 0}; // SUB Rd==Rs
        vecs[8]  = '{16'h5AFE, 16'h0010, 16'h7777, 16'h000E, 5'b10000, 1, 16'h0010, 16'hFFFE, 1, 5'b10000, 0}; // ADDI neg
        vecs[9]  = '{16'hAB23, 16'h0001, 16'h0002, 16'hFFFF, 5'b01000, 1, 16'h0001, 16'h0002, 0, 5'b01000, 0}; // CMPU
        vecs[10] = '{16'h8C43, 16'h0001, 16'h0004, 16'h0010, 5'b11111, 1, 16'h0001, 16'h0004, 1, 5'b01000, 0}; // LSH reg
        vecs[11] = '{16'h8D05, 16'h00F0, 16'h3333, 16'h1E00, 5'b00000, 1, 16'h00F0, 16'h0005, 1, 5'b01000, 0}; // shift imm
        vecs[12] = '{16'hBE80, 16'h0100, 16'h4444, 16'h0180, 5'b10000, 1, 16'h0100, 16'hFF80, 0, 5'b10000, 0}; // CMPI
        vecs[13] = '{16'h3123, 16'h0000, 16'h0000, 16'h1111, 5'b01111, 0, 16'h0000, 16'h0000, 0, 5'b10000, 1}; // bad opcode
        vecs[14] = '{16'h6280, 16'h0001, 16'h5555, 16'h0081, 5'b00000, 1, 16'h0001, 16'h0080, 1, 5'b00000, 0}; // ADDUI zext
        vecs[15] = '{16'h0140, 16'h0000, 16'h0000, 16'h0001, 5'b11111, 0, 16'h0000, 16'h0000, 0, 5'b00000, 1}; // 0000_0100
        vecs[16] = '{16'hA170, 16'h0000, 16'h0000, 16'h0001, 5'b11111, 0, 16'h0000, 16'h0000, 0, 5'b00000, 1}; // 1010_0111
        vecs[17] = '{16'h0263, 16'hFFFF, 16'h0002, 16'h0001, 5'b10000, 1, 16'hFFFF, 16'h0002, 1, 5'b10000, 0}; // ADDU
        vecs[18] = '{16'hA412, 16'h0001, 16'h0001, 16'h0002, 5'b00000, 1, 16'h0001, 16'h0001, 1, 5'b00000, 0}; // ADDCU
        vecs[19] = '{16'h0313, 16'h00FF, 16'h00FF, 16'h00FF, 5'b11111, 1, 16'h00FF, 16'h00FF, 1, 5'b00000, 0}; // AND
        vecs[20] = '{16'hE703, 16'h0004, 16'h0000, 16'h000C, 5'b11111, 1, 16'h0004, 16'h0003, 1, 5'b00000, 0}; // MULI
        vecs[21] = '{16'h7801, 16'h7FFF, 16'h0000, 16'h8000, 5'b00101, 1, 16'h7FFF, 16'h0001, 1, 5'b00101, 0}; // ADDCI

        for (int i = 0; i < 16; i++) regs[i] = '0;
        rst_n       = 1'b0;
        instr_valid = 1'b0;
        instr       = '0;
        alu_s       = '0;
        alu_flags   = '0;

        // Reset state
        #3;
        chk("rst_ready_low", instr_ready, 0);
        #9;
        rst_n = 1'b1;
        #1;
        chk("rst_ready", instr_ready, 1);
        chk("rst_wb_en", wb_en, 0);
        chk("rst_done", done, 0);
        chk("rst_illegal", illegal, 0);
        chk("rst_psr", psr_flags, 0);
        chk("rst_alu_a", alu_a, 0);
        chk("rst_alu_b", alu_b, 0);
        chk("rst_alu_op", {alu_opcode, alu_opext}, 0);
        chk("rst_wb_addr_data", {wb_addr, wb_data}, 0);
        chk("rst_rd_addrs", {ra_addr, rb_addr}, 0);
        @(posedge clk); #1;

        for (int i = 0; i < 22; i++) run_vec(vecs[i], i);

        // instr_valid held across two words: second accepted only at cycle 4
        regs[1] = 16'h7FFF; regs[2] = 16'h0001; regs[9] = 16'h0042;
        instr = 16'h0152; instr_valid = 1'b1;
        @(posedge clk); #1;
        instr = 16'h0999;
        for (int c = 1; c <= 3; c++) begin
            chk($sformatf("hold_ready_c%0d", c), instr_ready, 0);
            if (c == 2) begin
                alu_s = 16'h8000; alu_flags = 5'b00100;
                chk("hold_first_opext", alu_opext, 4'h5);
                chk("hold_first_a", alu_a, 16'h7FFF);
            end
            if (c == 3) begin
                chk("hold_first_wb_addr", wb_addr, 4'h1);
                chk("hold_first_psr", psr_flags, 5'b00100);
            end
            @(posedge clk); #1;
        end
        chk("hold_ready_c4", instr_ready, 1);
        @(posedge clk); #1;
        instr_valid = 1'b0;
        chk("hold_ready_c5", instr_ready, 0);
        @(posedge clk); #1;
        alu_s = 16'h0000; alu_flags = 5'b00010;
        chk("hold_second_opext", alu_opext, 4'h9);
        chk("hold_second_a", alu_a, 16'h0042);
        @(posedge clk); #1;
        chk("hold_second_wb_en", wb_en, 1);
        chk("hold_second_wb_addr", wb_addr, 4'h9);
        chk("hold_second_psr", psr_flags, 5'b00010);
        @(posedge clk); #1;
        chk("hold_second_ready", instr_ready, 1);

        // Reset during EXEC of ADD discards writeback and PSR update
        instr = 16'h0152; instr_valid = 1'b1;
        @(posedge clk); #1;
        instr_valid = 1'b0;
        @(posedge clk); #1;
        alu_s = 16'h8000; alu_flags = 5'b00100;
        #2;
        rst_n = 1'b0;
        #1;
        chk("rstx_ready_low", instr_ready, 0);
        chk("rstx_psr_now", psr_flags, 0);
        @(posedge clk); #1;
        chk("rstx_wb_en_in_rst", wb_en, 0);
        chk("rstx_done_in_rst", done, 0);
        #2;
        rst_n = 1'b1;
        #1;
        chk("rstx_ready", instr_ready, 1);
        chk("rstx_psr", psr_flags, 0);
        @(posedge clk); #1;
        chk("rstx_wb_en_after", wb_en, 0);
        chk("rstx_done_after", done, 0);
        chk("rstx_ready_after", instr_ready, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/cr16_exec_ctrl.md
# cr16_exec_ctrl

Instruction-issue controller that drives the CR16-style ALU datapath from the other side: it accepts 16-bit instruction words over a valid/ready handshake, decodes them into the ALU's `opcode`/`opext` fields and operands, captures the ALU result and CLFZN flags, and performs register writeback. It sits between the fetch stage and the register file/ALU pair. It owns the architectural PSR flag register.

## Interface
- No parameters; data width 16, register index width 4 (constants in package).
- `clk`  in  1  rising-edge clock
- `rst_n`  in  1  asynchronous, active-low reset
- `instr_valid`  in  1  instruction word available
- `instr_ready`  out  1  controller can accept an instruction
- `instr`  in  16  `[15:12]` opcode, `[11:8]` Rdest, `[7:4]` opext/imm_hi, `[3:0]` Rsrc/imm_lo
- `ra_addr`, `rb_addr`  out  4  register-file read addresses (Rdest, Rsrc)
- `ra_data`, `rb_data`  in  16  register-file read data (combinational read)
- `alu_a`, `alu_b`  out  16  ALU operands
- `alu_opcode`, `alu_opext`  out  4  ALU function select
- `alu_s`  in  16  ALU result
- `alu_flags`  in  5  ALU CLFZN (`[4]` C, `[3]` L, `[2]` F, `[1]` Z, `[0]` N)
- `wb_en`  out  1  one-cycle register write strobe
- `wb_addr`  out  4  write address (= Rdest)
- `wb_data`  out  16  write data
- `psr_flags`  out  5  architectural CLFZN register
- `done`  out  1  one-cycle pulse at instruction retirement
- `illegal`  out  1  one-cycle pulse, coincident with `done`, for undecodable words

## Operation
- FSM: IDLE → READ → EXEC → WB → IDLE. `instr_ready` = 1 only in IDLE.
- IDLE: on `instr_valid & instr_ready`, latch `instr`; go to READ.
- READ: drive `ra_addr`=Rdest, `rb_addr`=Rsrc; register operand A/B into operand regs per class rules; go to EXEC.
- EXEC: drive `alu_*` from operand regs and latched opcode/opext; at the clock edge capture `alu_s` and `alu_flags`; go to WB.
- WB: assert `wb_en` if class writes back; update `psr_flags` if class sets flags; pulse `done`; go to IDLE.
- Register-form classes: opcode 0000 (opext 0001,0010,0011,0101,0110,0111,1001,1011,1101,1110), opcode 1010 (opext 0001–0110), opcode 1000 with opext 0100. Operands A=R[Rdest], B=R[Rsrc]; exception MOV (0000_1101): A=R[Rsrc].
- Immediate classes: opcodes 0101,0110,0111,1000 (opext≠0100),1001,1011,1101,1110. imm8 = `instr[7:0]`. ADDUI (0110) zero-extends; all others sign-extend. A=R[Rdest], B=imm; exception MOVI (1101): A=imm. `alu_opext` = `instr[7:4]` in every case.
- Flag update (PSR ← captured flags): ADD/ADDI/ADDU/ADDUI/ADDC/ADDCI/ADDCU/ADDCUI/SUB/SUBI/CMP/CMPI/CMPU. All others leave PSR unchanged.
- Writeback: every legal class except CMP, CMPI, CMPU (1010_0010).
- NOP (0000_0000) and any unlisted encoding: no writeback, no PSR update; unlisted encodings pulse `illegal`; NOP does not.
- Rdest == Rsrc is legal; operands are sampled in READ, so no hazard.

## Timing
- Reset values: `instr_ready`=1 after deassert (0 while `rst_n`=0), `wb_en`=0, `done`=0, `illegal`=0, `psr_flags`=5'b00000, `alu_*`/`wb_*`/`ra_addr`/`rb_addr`=0, state IDLE.
- Accept at edge 0; READ cycle 1; EXEC cycle 2; `wb_en`/`done`/PSR visible cycle 3; `instr_ready` high again cycle 4. Throughput one instruction per 4 cycles.
- `alu_*` outputs registered; stable for the whole EXEC cycle.
- `instr_valid` held without accept (not IDLE) is ignored; the word is not consumed.
- Reset asserted in any state: immediate return to IDLE, pending writeback and PSR update discarded.

## Structure
- Shared package `cr16_pkg`: opcode/opext localparams, CLFZN bit indices, state enum, operand-class enum.
- One combinational sub-module `cr16_decode`: instr → class, writes_back, sets_flags, imm sign/zero select, A-source select, illegal.

## Test plan
- ADD R1=0x7FFF, R2=0x0001 (0x0152) → cycle 3: `wb_en`=1, `wb_addr`=1, `wb_data`=0x8000, `psr_flags`=5'b00100.
- ADDUI R3=0xFFFF, imm 0x01 (0x6301) → `wb_data`=0x0000, `psr_flags`=5'b10010; B driven as 0x0001.
- MOVI R4, 0x80 (0xD480) → `wb_data`=0xFF80; PSR unchanged from previous value.
- CMP R5,R6 (0x05B6) → `wb_en` stays 0, `done`=1, PSR updated; encoding 0x0F00 → `illegal`=1, `done`=1, no writeback.
- `instr_valid` held high across two words → second accepted only at cycle 4; `instr_ready` low cycles 1–3.
- `rst_n` pulsed low during EXEC of ADD → no `wb_en`, `psr_flags`=0, `instr_ready`=1 after release.
